updi_uart_rx: RTL and testbench
===============================

Name: updi_uart_rx

Overview:
Receive half of the UPDI PHY UART. It oversamples the synchronized single-wire UPDI line and decodes UPDI 8E2 frames: 1 start bit, 8 data bits LSB first, even parity, 2 stop bits. Good bytes are pushed into the PHY RX FIFO that the programmer drains. Parity, framing and overrun errors are flagged. BREAK conditions are reported separately and never written to the FIFO.

Parameters:
UART_CLK_DIV, 1736, clk cycles per UART bit (100 MHz / 57600); must be >= 8.
CNT_BITS, $clog2(UART_CLK_DIV)+1, width of the bit-timing counter.

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
rx_in  input  1  raw UPDI line level (pin input path); asynchronous to clk
enable  input  1  1 = start-bit detection allowed; 0 = ignore new frames (own TX in progress)
fifo_data  output  8  received byte, valid when fifo_wr_en = 1
fifo_wr_en  output  1  one-cycle write strobe into RX FIFO
fifo_full  input  1  RX FIFO full
break_detected  output  1  one-cycle pulse when a BREAK ends (line returns high)
err_flags  output  3  sticky: [0] parity error, [1] frame error, [2] overrun
rx_error  output  1  OR of err_flags
clear_errors  input  1  clears err_flags next cycle; set events in the same cycle win
busy  output  1  1 whenever the state is not IDLE

Behaviour:
- Synchronizer: 2-FF synchronizer on rx_in, reset to 1. All logic uses rx_s, the second stage.
- Reset values:
  - fifo_data = 0, fifo_wr_en = 0, break_detected = 0.
  - err_flags = 0, rx_error = 0, busy = 0.
  - State = IDLE; prev rx_s = 1.
- Reset mid-frame abandons the frame. No write, no flag.
- States: IDLE, START, DATA, PARITY, STOP1, STOP2, BREAK_WAIT.
- IDLE → START when enable = 1 and rx_s falls (prev 1, now 0). Let t0 be that cycle. Load the counter with UART_CLK_DIV/2 (integer divide).
- Counter decrements every cycle. A sample is taken when it reaches 0, then the counter reloads with UART_CLK_DIV - 1. Samples therefore occur at t0 + DIV/2 + k*DIV, k = 0..11.
- START sample:
  - rx_s = 1: glitch, go to IDLE with no flag.
  - rx_s = 0: go to DATA.
- DATA: shift rx_s into shift[7] and shift right, 8 samples. Result is LSB first.
- PARITY: store the parity bit p.
- STOP1 sample:
  - If rx_s = 0 and shift == 0 and p == 0: BREAK. Go to BREAK_WAIT, with no write and no error.
  - Otherwise, if rx_s = 0: set err_flags[1] and go to IDLE.
  - Otherwise go to STOP2.
- STOP2 sample:
  - rx_s = 0: set err_flags[1], go to IDLE, no write.
  - Else if ^{shift, p} = 1: set err_flags[0], no write.
  - Else if fifo_full = 1: set err_flags[2] and drop the byte.
  - Else drive fifo_data = shift and pulse fifo_wr_en for exactly the next cycle, at t0 + DIV/2 + 11*DIV + 1.
  - In all cases return to IDLE. Start detection may then fire from the next cycle.
- BREAK_WAIT: stay while rx_s = 0. On the first cycle rx_s = 1, pulse break_detected for one cycle and go to IDLE.
- enable gates only the IDLE → START transition. Deasserting enable mid-frame does not abort the frame.
- fifo_data holds its last written value between strobes.
- clear_errors and a new error in the same cycle: the new error bit stays set; other bits clear.
- busy = (state != IDLE).

Test Plan:
- UART_CLK_DIV = 16, enable = 1, frame 0x55 with p = 0 and 2 stop bits → fifo_wr_en single pulse with fifo_data = 0x55, 185 cycles after t0; err_flags = 0.
- Frame 0x01 with p = 0 (bad parity) → no fifo_wr_en; err_flags = 3'b001, rx_error = 1. Then clear_errors pulse → err_flags = 0.
- Frame 0xA3 with p = 0, stop1 driven low → no write; err_flags[1] = 1. Then a valid 0x3C frame → written correctly, err_flags[1] stays set.
- Line held low for 24 bit times, then high → no write; break_detected pulses once, one cycle after rx_s returns high; err_flags = 0.
- Low glitch of 4 cycles with DIV = 16 → back to IDLE, no write, no flag. Falling edge while enable = 0 → busy stays 0.
- fifo_full = 1 during a valid 0x7E frame → no write, err_flags[2] = 1. Separately, rst asserted at data bit 3 → all outputs 0 next cycle, and the following frame decodes normally.

Source files
------------

// File: rtl/updi_uart_rx_if.sv
// rtl/updi_uart_rx_if.sv - RX FIFO write port between the UPDI UART receiver and its FIFO
// fifo_data  : received byte, valid with fifo_wr_en
// fifo_wr_en : one-cycle write strobe
// fifo_full  : FIFO cannot accept a byte
interface updi_uart_rx_if;
    logic [7:0] fifo_data;
    logic       fifo_wr_en;
    logic       fifo_full;

    modport master (
        output fifo_data,
        output fifo_wr_en,
        input  fifo_full
    );

    modport slave (
        input  fifo_data,
        input  fifo_wr_en,
        output fifo_full
    );
endinterface

// File: rtl/updi_uart_rx.sv
// rtl/updi_uart_rx.sv - UPDI 8E2 UART receiver with parity/frame/overrun and BREAK detection
// clk, rst       : system clock, synchronous active-high reset
// rx_in          : raw asynchronous UPDI line
// enable         : allows start-bit detection
// fifo           : RX FIFO write port (master side)
// break_detected : one-cycle pulse when a BREAK ends
// err_flags      : sticky {overrun, frame, parity}; rx_error is their OR
// clear_errors   : clears err_flags, new errors in the same cycle win
// busy           : receiver is not idle
module updi_uart_rx #(
    parameter int UART_CLK_DIV = 1736,
    parameter int CNT_BITS     = $clog2(UART_CLK_DIV) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_in,
    input  logic                  enable,
    updi_uart_rx_if.master        fifo,
    output logic                  break_detected,
    output logic [2:0]            err_flags,
    output logic                  rx_error,
    input  logic                  clear_errors,
    output logic                  busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP1,
        S_STOP2,
        S_BREAK_WAIT
    } state_t;

    // cnt holds the number of cycles left until the next sample; loading
    // DIV/2-1 on the edge cycle puts the first sample DIV/2 cycles after it.
    localparam logic [CNT_BITS-1:0] HALF_LOAD = CNT_BITS'(UART_CLK_DIV / 2 - 1);
    localparam logic [CNT_BITS-1:0] FULL_LOAD = CNT_BITS'(UART_CLK_DIV - 1);

    state_t                state;
    state_t                state_next;
    logic                  rx_meta;
    logic                  rx_s;
    logic                  rx_prev;
    logic [CNT_BITS-1:0]   cnt;
    logic [2:0]            bit_idx;
    logic [7:0]            shift;
    logic                  par;
    logic                  sample;
    logic                  start_edge;
    logic                  is_break;
    logic                  do_write;
    logic                  do_break;
    logic [2:0]            err_set;

    assign sample     = (cnt == '0);
    assign start_edge = enable && rx_prev && !rx_s;
    assign is_break   = (shift == 8'h00) && !par;
    assign rx_error   = |err_flags;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:       if (start_edge) state_next = S_START;
            S_START:      if (sample) state_next = rx_s ? S_IDLE : S_DATA;
            S_DATA:       if (sample && bit_idx == 3'd7) state_next = S_PARITY;
            S_PARITY:     if (sample) state_next = S_STOP1;
            S_STOP1: begin
                if (sample) begin
                    if (rx_s)          state_next = S_STOP2;
                    else if (is_break) state_next = S_BREAK_WAIT;
                    else               state_next = S_IDLE;
                end
            end
            S_STOP2:      if (sample) state_next = S_IDLE;
            S_BREAK_WAIT: if (rx_s) state_next = S_IDLE;
            default:      state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy     = (state != S_IDLE);
        do_write = 1'b0;
        do_break = 1'b0;
        err_set  = 3'b000;
        case (state)
            S_STOP1: begin
                if (sample && !rx_s && !is_break) err_set[1] = 1'b1;
            end
            S_STOP2: begin
                if (sample) begin
                    if (!rx_s)              err_set[1] = 1'b1;
                    else if (^{shift, par}) err_set[0] = 1'b1;
                    else if (fifo.fifo_full) err_set[2] = 1'b1;
                    else                    do_write   = 1'b1;
                end
            end
            S_BREAK_WAIT: begin
                if (rx_s) do_break = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta         <= 1'b1;
            rx_s            <= 1'b1;
            rx_prev         <= 1'b1;
            cnt             <= '0;
            bit_idx         <= 3'd0;
            shift           <= 8'h00;
            par             <= 1'b0;
            fifo.fifo_data  <= 8'h00;
            fifo.fifo_wr_en <= 1'b0;
            break_detected  <= 1'b0;
            err_flags       <= 3'b000;
        end else begin
            rx_meta         <= rx_in;
            rx_s            <= rx_meta;
            rx_prev         <= rx_s;
            fifo.fifo_wr_en <= do_write;
            break_detected  <= do_break;
            if (do_write) fifo.fifo_data <= shift;
            err_flags <= err_set | (clear_errors ? 3'b000 : err_flags);

            if (state == S_IDLE) begin
                cnt     <= HALF_LOAD;
                bit_idx <= 3'd0;
            end else if (sample) begin
                cnt <= FULL_LOAD;
            end else begin
                cnt <= cnt - 1'b1;
            end

            if (sample && state == S_DATA) begin
                shift   <= {rx_s, shift[7:1]};
                bit_idx <= bit_idx + 3'd1;
            end
            if (sample && state == S_PARITY) par <= rx_s;
        end
    end

endmodule

// File: tb/tb_updi_uart_rx.sv
// tb/tb_updi_uart_rx.sv - directed self-checking bench for updi_uart_rx
module tb_updi_uart_rx;
    localparam int DIV = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_in = 1'b1;
    logic       enable = 1'b1;
    logic       clear_errors = 1'b0;
    logic       break_detected;
    logic [2:0] err_flags;
    logic       rx_error;
    logic       busy;

    int passes = 0;
    int total = 0;
    int cyc = 0;
    int wr_cnt = 0;
    int wr_cyc = 0;
    int brk_cnt = 0;
    int brk_cyc = 0;
    int t_start = 0;
    int t_high = 0;
    int wr_base = 0;
    int brk_base = 0;
    logic [7:0] wr_data = 8'h00;

    updi_uart_rx_if fif();

    updi_uart_rx #(.UART_CLK_DIV(DIV)) dut (
        .clk            (clk),
        .rst            (rst),
        .rx_in          (rx_in),
        .enable         (enable),
        .fifo           (fif),
        .break_detected (break_detected),
        .err_flags      (err_flags),
        .rx_error       (rx_error),
        .clear_errors   (clear_errors),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (fif.fifo_wr_en) begin
            wr_cnt  <= wr_cnt + 1;
            wr_data <= fif.fifo_data;
            wr_cyc  <= cyc;
        end
        if (break_detected) begin
            brk_cnt <= brk_cnt + 1;
            brk_cyc <= cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Frame: start, 8 data LSB first, parity, stop1, stop2, then line high.
    task automatic send_frame(input logic [7:0] d, input logic p, input logic s1, input logic s2);
        logic [11:0] bits;
        bits = {s2, s1, p, d, 1'b0};
        tick(1);
        t_start = cyc;
        for (int i = 0; i < 12; i++) begin
            rx_in = bits[i];
            tick(DIV);
        end
        rx_in = 1'b1;
        tick(8);
    endtask

    task automatic pulse_clear();
        clear_errors = 1'b1;
        tick(1);
        clear_errors = 1'b0;
    endtask

    initial begin
        logic [7:0] part;
        fif.fifo_full = 1'b0;
        tick(3);
        rst = 1'b0;
        @(negedge clk);
        check("rst_wr_en", fif.fifo_wr_en, 1'b0);
        check("rst_data", fif.fifo_data, 8'h00);
        check("rst_break", break_detected, 1'b0);
        check("rst_err", err_flags, 3'b000);
        check("rst_rx_error", rx_error, 1'b0);
        check("rst_busy", busy, 1'b0);
        tick(4);

        // Good frame, write 185 cycles after t0 (+2 synchronizer cycles)
        wr_base = wr_cnt;
        send_frame(8'h55, 1'b0, 1'b1, 1'b1);
        check("f55_count", wr_cnt - wr_base, 1);
        check("f55_data", wr_data, 8'h55);
        check("f55_latency", wr_cyc - t_start, 187);
        check("f55_err", err_flags, 3'b000);

        // Bad parity
        wr_base = wr_cnt;
        send_frame(8'h01, 1'b0, 1'b1, 1'b1);
        check("par_nowrite", wr_cnt - wr_base, 0);
        check("par_err", err_flags, 3'b001);
        check("par_rx_error", rx_error, 1'b1);
        check("par_data_hold", fif.fifo_data, 8'h55);
        pulse_clear();
        check("par_cleared", err_flags, 3'b000);

        // Frame error on stop1, then a good frame keeps the sticky flag
        wr_base = wr_cnt;
        send_frame(8'hA3, 1'b0, 1'b0, 1'b1);
        check("fe_nowrite", wr_cnt - wr_base, 0);
        check("fe_err", err_flags, 3'b010);
        send_frame(8'h3C, 1'b0, 1'b1, 1'b1);
        check("f3c_count", wr_cnt - wr_base, 1);
        check("f3c_data", wr_data, 8'h3C);
        check("f3c_err_sticky", err_flags, 3'b010);
        pulse_clear();
        check("fe_cleared", err_flags, 3'b000);

        // BREAK: 24 bit times low
        wr_base = wr_cnt;
        brk_base = brk_cnt;
        tick(1);
        rx_in = 1'b0;
        tick(24 * DIV);
        rx_in = 1'b1;
        t_high = cyc;
        tick(10);
        check("brk_nowrite", wr_cnt - wr_base, 0);
        check("brk_count", brk_cnt - brk_base, 1);
        check("brk_latency", brk_cyc - t_high, 3);
        check("brk_err", err_flags, 3'b000);
        check("brk_idle", busy, 1'b0);

        // 4-cycle glitch
        wr_base = wr_cnt;
        rx_in = 1'b0;
        tick(4);
        rx_in = 1'b1;
        tick(3);
        check("glitch_busy", busy, 1'b1);
        tick(20);
        check("glitch_idle", busy, 1'b0);
        check("glitch_nowrite", wr_cnt - wr_base, 0);
        check("glitch_err", err_flags, 3'b000);

        // Falling edge while disabled
        enable = 1'b0;
        rx_in = 1'b0;
        tick(10);
        check("dis_busy_low", busy, 1'b0);
        rx_in = 1'b1;
        tick(5);
        enable = 1'b1;
        tick(2);
        check("dis_busy_after", busy, 1'b0);

        // Overrun
        wr_base = wr_cnt;
        fif.fifo_full = 1'b1;
        send_frame(8'h7E, 1'b0, 1'b1, 1'b1);
        fif.fifo_full = 1'b0;
        check("ovr_nowrite", wr_cnt - wr_base, 0);
        check("ovr_err", err_flags, 3'b100);
        check("ovr_rx_error", rx_error, 1'b1);
        pulse_clear();
        check("ovr_cleared", err_flags, 3'b000);

        // Reset during data bit 3
        wr_base = wr_cnt;
        part = 8'h5A;
        rx_in = 1'b0;
        tick(DIV);
        for (int i = 0; i < 3; i++) begin
            rx_in = part[i];
            tick(DIV);
        end
        rx_in = part[3];
        tick(8);
        check("mid_busy", busy, 1'b1);
        rst = 1'b1;
        rx_in = 1'b1;
        tick(1);
        rst = 1'b0;
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_wr_en", fif.fifo_wr_en, 1'b0);
        check("mid_rst_data", fif.fifo_data, 8'h00);
        check("mid_rst_break", break_detected, 1'b0);
        check("mid_rst_err", err_flags, 3'b000);
        tick(40);
        check("mid_nowrite", wr_cnt - wr_base, 0);
        send_frame(8'h96, 1'b0, 1'b1, 1'b1);
        check("f96_count", wr_cnt - wr_base, 1);
        check("f96_data", wr_data, 8'h96);
        check("f96_latency", wr_cyc - t_start, 187);
        check("f96_err", err_flags, 3'b000);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
